// File: rtl/shifter_pkg.sv
// Types and helpers shared by the bit-shifter family.
package shifter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } obs_state_t;

  // Counter must hold the full word length, not just its index range.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sys_structs.sv
// Shared system-level types: a clock domain bundle carried as one port.
package sys_structs;

  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_domain;

endpackage

// File: rtl/output_bit_shifter_lane.sv
// One lane: SHIFT_WIDTH-bit load/shift register, MSB presented on msb_o.
module output_bit_shifter_lane #(
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   shift,
  input  logic [SHIFT_WIDTH-1:0] load_data,
  output logic                   msb_o
);

  logic [SHIFT_WIDTH-1:0] word_d, word_q;

  // NOTE: default first so every path assigns word_d and no latch is inferred.
  always_comb begin
    word_d = word_q;
    if (en) begin
      if (clear)      word_d = '0;
      else if (load)  word_d = load_data;
      else if (shift) word_d = {word_q[SHIFT_WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: flops use non-blocking assignment so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign msb_o = word_q[SHIFT_WIDTH-1];

endmodule

// File: rtl/output_bit_shifter.sv
// Parallel-in, serial-out shifter: SHIFT_DEPTH lanes emitted MSB-first.
// Define OUTPUT_BIT_SHIFTER_PRELOAD_EN to add a one-word holding register.
module output_bit_shifter
  import shifter_pkg::*;
#(
  parameter int SHIFT_DEPTH = 4,
  parameter int SHIFT_WIDTH = 4
) (
  input  sys_structs::clk_domain                  sys_dom_i,
  input  logic                                    async_rst_i,
  input  logic                                    load_valid_i,
  output logic                                    load_ready_o,
  input  logic [SHIFT_DEPTH-1:0][SHIFT_WIDTH-1:0] load_data_i,
  input  logic                                    shift_en_i,
  input  logic                                    clear_en_i,
  output logic [SHIFT_DEPTH-1:0]                  data_o,
  output logic                                    busy_o,
  output logic                                    done_o
);

  localparam int CNT_W = count_width(SHIFT_WIDTH);

  logic clk, clk_en, unused_sync_rst;
  assign clk             = sys_dom_i.clk;
  assign clk_en          = sys_dom_i.clk_en;
  assign unused_sync_rst = sys_dom_i.sync_rst;

  obs_state_t             state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   done_d, done_q;
  logic                   clear, accept, fire, last, lane_load;
  logic [SHIFT_DEPTH-1:0][SHIFT_WIDTH-1:0] lane_data;

`ifdef OUTPUT_BIT_SHIFTER_PRELOAD_EN
  logic [SHIFT_DEPTH-1:0][SHIFT_WIDTH-1:0] hold_d, hold_q;
  logic                                    hold_valid_d, hold_valid_q;
`endif

  assign clear  = clk_en & clear_en_i;
  assign accept = load_valid_i & load_ready_o;
  assign fire   = clk_en & shift_en_i & ~clear_en_i & (state_q == SHIFT);
  assign last   = fire & (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; a refill on the final shift keeps the FSM in SHIFT.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SHIFT;
        SHIFT:   if (last && !lane_load) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy_o = (state_q == SHIFT);
    done_o = done_q & clk_en;
`ifdef OUTPUT_BIT_SHIFTER_PRELOAD_EN
    load_ready_o = clk_en & ~clear_en_i & ~hold_valid_q & ~async_rst_i;
`else
    load_ready_o = clk_en & ~clear_en_i & (state_q == IDLE) & ~async_rst_i;
`endif
  end

  // Lane load selection, bit counter and done pulse.
  always_comb begin
    lane_data = load_data_i;
    done_d    = done_q;
    cnt_d     = cnt_q;
`ifdef OUTPUT_BIT_SHIFTER_PRELOAD_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    lane_load    = (accept & (state_q == IDLE)) | (last & (hold_valid_q | accept));
    if (hold_valid_q) lane_data = hold_q;
    if (clear) begin
      hold_valid_d = 1'b0;
    end else if (last && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end else if (accept && (state_q == SHIFT) && !last) begin
      hold_d       = load_data_i;
      hold_valid_d = 1'b1;
    end
`else
    lane_load = accept;
`endif
    if (clk_en) done_d = last;
    if (clear)          cnt_d = '0;
    else if (lane_load) cnt_d = CNT_W'(SHIFT_WIDTH);
    else if (fire)      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef OUTPUT_BIT_SHIFTER_PRELOAD_EN
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  for (genvar i = 0; i < SHIFT_DEPTH; i++) begin : g_lane
    output_bit_shifter_lane #(.SHIFT_WIDTH(SHIFT_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (async_rst_i),
      .en        (clk_en),
      .clear     (clear),
      .load      (lane_load),
      .shift     (fire),
      .load_data (lane_data[i]),
      .msb_o     (data_o[i])
    );
  end

endmodule

// File: tb/tb_output_bit_shifter.sv
// Self-checking bench: word-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_output_bit_shifter;

  localparam int D = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic load_valid = 1'b0;
  logic shift_en = 1'b0;
  logic clear_en = 1'b0;
  logic [D-1:0][W-1:0] ld = '0;
  logic load_ready, busy, done;
  logic [D-1:0] data;
  sys_structs::clk_domain sys_dom;

  assign sys_dom = '{clk, clk_en, 1'b0};

  output_bit_shifter #(.SHIFT_DEPTH(D), .SHIFT_WIDTH(W)) dut (
    .sys_dom_i    (sys_dom),
    .async_rst_i  (rst),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_data_i  (ld),
    .shift_en_i   (shift_en),
    .clear_en_i   (clear_en),
    .data_o       (data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Word-level model: current word per lane, bits consumed so far, optional held word.
  logic [W-1:0] m_word [D];
  logic [W-1:0] m_hold [D];
  logic m_busy, m_done, m_hold_v;
  int   m_pos;

  function automatic logic exp_ready();
`ifdef OUTPUT_BIT_SHIFTER_PRELOAD_EN
    return clk_en & ~clear_en & ~rst & ~m_hold_v;
`else
    return clk_en & ~clear_en & ~rst & ~m_busy;
`endif
  endfunction

  function automatic logic [D-1:0] exp_data();
    logic [D-1:0] e = '0;
    if (m_busy) for (int i = 0; i < D; i++) e[i] = m_word[i][W-1-m_pos];
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic acc, fire_m, last_m;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_hold_v = 1'b0; m_pos = 0;
      for (int i = 0; i < D; i++) begin m_word[i] = '0; m_hold[i] = '0; end
    end else if (clk_en) begin
      acc    = load_valid & exp_ready();
      fire_m = shift_en & m_busy & ~clear_en;
      last_m = fire_m & (m_pos == W-1);
      if (clear_en) begin
        m_busy = 1'b0; m_pos = 0; m_hold_v = 1'b0; m_done = 1'b0;
      end else begin
        m_done = last_m;
        if (fire_m) m_pos++;
        if (last_m) begin
          m_pos = 0;
          if (m_hold_v) begin
            for (int i = 0; i < D; i++) m_word[i] = m_hold[i];
            m_hold_v = 1'b0;
          end else if (acc) begin
            for (int i = 0; i < D; i++) m_word[i] = ld[i];
          end else begin
            m_busy = 1'b0;
          end
        end else if (acc) begin
          if (!m_busy) begin
            for (int i = 0; i < D; i++) m_word[i] = ld[i];
            m_busy = 1'b1; m_pos = 0;
          end else begin
            for (int i = 0; i < D; i++) m_hold[i] = ld[i];
            m_hold_v = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("data_o",       32'(data),       32'(exp_data()));
    check("busy_o",       32'(busy),       32'(m_busy));
    check("done_o",       32'(done),       32'(m_done & clk_en));
    check("load_ready_o", 32'(load_ready), 32'(exp_ready()));
  end

  task automatic cyc(input logic v, input logic [D-1:0][W-1:0] d,
                     input logic sh, input logic cl, input logic ce);
    load_valid = v; ld = d; shift_en = sh; clear_en = cl; clk_en = ce;
    @(posedge clk); #2;
  endtask

  localparam logic [D-1:0][W-1:0] S1 = {4'h0, 4'hF, 4'h5, 4'hA};
  localparam logic [D-1:0][W-1:0] L0A = {4'h0, 4'h0, 4'h0, 4'hA};
  localparam logic [D-1:0][W-1:0] L03 = {4'h0, 4'h0, 4'h0, 4'h3};

  task automatic run_s1();
    logic [D-1:0] want [4];
    want[0] = 4'b0110; want[1] = 4'b0101; want[2] = 4'b0110; want[3] = 4'b0000;
    cyc(1'b1, S1, 1'b0, 1'b0, 1'b1);
    check("s1 first bits", 32'(data), 32'h5);
    check("s1 model first bits", 32'(exp_data()), 32'h5);
    check("s1 busy", 32'(busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check($sformatf("s1 shift%0d data", k+1), 32'(data), 32'(want[k]));
      check($sformatf("s1 shift%0d done", k+1), 32'(done), (k == 3) ? 32'h1 : 32'h0);
    end
    check("s1 busy fell", 32'(busy), 32'h0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("s1 done single", 32'(done), 32'h0);
  endtask

  initial begin
    logic [3:0] bits;
    logic [7:0] stream;
    logic sh_seq [6];
    logic ce_seq [6];
    repeat (2) @(posedge clk);
    #2;
    check("reset data", 32'(data), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset ready", 32'(load_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("release ready", 32'(load_ready), 32'h1);

    // 1: basic word
    run_s1();

    // 2: strobes qualified by clk_en
    sh_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ce_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    cyc(1'b1, L0A, 1'b0, 1'b0, 1'b1);
    bits = '0;
    for (int k = 0; k < 6; k++) begin
      if (sh_seq[k] && ce_seq[k]) bits = {bits[2:0], data[0]};
      cyc(1'b0, '0, sh_seq[k], 1'b0, ce_seq[k]);
      if (k < 5) check($sformatf("s2 no early done %0d", k), 32'(done), 32'h0);
    end
    check("s2 lane0 bits", 32'(bits), 32'hA);
    check("s2 done", 32'(done), 32'h1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // 3: clear beats shift and load
    cyc(1'b1, S1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    load_valid = 1'b1; ld = S1; shift_en = 1'b1; clear_en = 1'b1;
    #1;
    check("s3 ready during clear", 32'(load_ready), 32'h0);
    @(posedge clk); #2;
    check("s3 busy", 32'(busy), 32'h0);
    check("s3 data", 32'(data), 32'h0);
    check("s3 done", 32'(done), 32'h0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("s3 done after", 32'(done), 32'h0);

    // 4: async reset mid-word
    cyc(1'b1, S1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("s4 async data", 32'(data), 32'h0);
    check("s4 async busy", 32'(busy), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_s1();

    // 5: shifts in IDLE ignored
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check("s5 data", 32'(data), 32'h0);
      check("s5 done", 32'(done), 32'h0);
    end

`ifdef OUTPUT_BIT_SHIFTER_PRELOAD_EN
    // 6: back-to-back words through the holding register
    cyc(1'b1, L0A, 1'b0, 1'b0, 1'b1);
    stream = {7'h0, data[0]};
    cyc(1'b1, L03, 1'b1, 1'b0, 1'b1);
    check("s6 ready with hold", 32'(load_ready), 32'h0);
    for (int k = 2; k <= 8; k++) begin
      stream = {stream[6:0], data[0]};
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
      check($sformatf("s6 done at shift %0d", k), 32'(done), (k == 4 || k == 8) ? 32'h1 : 32'h0);
      if (k == 4) check("s6 busy across words", 32'(busy), 32'h1);
    end
    check("s6 lane0 stream", 32'(stream), 32'hA3);
    check("s6 busy end", 32'(busy), 32'h0);
`else
    stream = '0;
    check("s6 unused stream", 32'(stream | 8'(data)), 32'h0);
`endif

    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
